my_cpu16_sequencer: RTL and testbench
=====================================

Name: my_cpu16_sequencer

Overview:
- Multi-cycle control FSM for the 16-bit CPU datapath.
- Fetches an instruction over a req/ack instruction-memory handshake and holds it in IR, which drives my_decoder.
- Steers register-file read addresses into my_ALU, latches the ALU result and writes it back.
- Advances the PC. One instruction in flight; no pipelining.

Parameters:
- PC_W, 8, program counter / instruction address width.
- RESET_PC, 0, PC value loaded on reset.
- HALT_OPC, 16'hFFFF, instruction encoding that stops the sequencer.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- imem_req  out  1  fetch request; high only in FETCH.
- imem_addr  out  PC_W  fetch address (= pc).
- imem_ack  in  1  instruction valid this cycle.
- imem_data  in  16  instruction word, sampled when imem_ack=1.
- ir  out  16  instruction register; feeds my_decoder.
- is_alu  in  1  decoder output: IR is an ALU operation.
- alu_r  in  16  ALU result (combinational from rf reads and decoder selects).
- rf_raddr_a  out  2  = ir[3:2], source A and destination.
- rf_raddr_b  out  2  = ir[1:0], source B.
- rf_we  out  1  register write strobe, one cycle.
- rf_waddr  out  2  write address.
- rf_wdata  out  16  write data.
- pc  out  PC_W  current program counter.
- halted  out  1  high in HALT.
- retired  out  16  count of completed instructions (ALU and NOP).

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high, named reset. Sampled only at the rising edge of clk.
- Reset values:
  - state=IDLE, pc=RESET_PC, ir=0, result=0, retired=0.
  - imem_req=0, rf_we=0, rf_waddr=0, rf_wdata=0, halted=0.
- Reset mid-operation: any state, including FETCH with a pending request, returns to IDLE at the next edge.
  - imem_req drops in that same cycle.
  - An imem_ack arriving in the reset cycle is ignored.
- States:
  - IDLE: one cycle, go to FETCH.
  - FETCH: imem_req=1, imem_addr=pc. Wait indefinitely for imem_ack. On ack, ir<=imem_data and go to DECODE.
  - DECODE: ir stable and decoder outputs settle.
    - If ir==HALT_OPC, go to HALT; pc and retired are unchanged.
    - Else if is_alu=0, treat as NOP: pc<=pc+1, retired<=retired+1, go to FETCH.
    - Else go to EXEC.
  - EXEC: result<=alu_r, go to WB.
  - WB: rf_we=1, rf_waddr=ir[3:2], rf_wdata=result. pc<=pc+1, retired<=retired+1, go to FETCH.
  - HALT: halted=1, imem_req=0. Leave only via reset.
- rf_raddr_a/b: combinational from ir, valid from DECODE onward.
- Latency for an ALU instruction: FETCH(≥1, ack cycle included) + DECODE + EXEC + WB = 4 cycles minimum.
- rf_we rises in the 4th cycle after the ack cycle begins.
- NOP latency: 2 cycles minimum.
- PC arithmetic: modulo 2^PC_W; the increment after address 2^PC_W-1 wraps to 0.
- retired: wraps from 16'hFFFF to 0.
- Write-back: rf_we is registered (asserted only while state==WB), never high in any other state. A write to a source register takes effect before the next instruction's DECODE.
- imem_ack outside FETCH is ignored.

Optional Feature:
- Macro: MY_SEQ_STEP_EN.
- Defined:
  - Adds input step (1 bit).
  - FETCH asserts imem_req only while step_armed=1.
  - step_armed is set by a step=1 sample and cleared on leaving WB, DECODE→FETCH (NOP), or DECODE→HALT.
  - Result: exactly one instruction per step pulse; extra pulses while armed are ignored.
  - step_armed resets to 0.
- Undefined: no step port; free-running.

Decomposition:
- Shared package my_cpu16_pkg:
  - state enum {IDLE, FETCH, DECODE, EXEC, WB, HALT}, 3-bit encoding.
  - IR field positions (DST_HI=3, DST_LO=2, SRC_HI=1, SRC_LO=0).
  - HALT_OPC default.
- Sub-module my_pc_counter: PC register with reset load, increment enable and wrap. Everything else lives in the FSM.

Test Plan:
- ALU write-back:
  - Stimulus: r0=65280, r1=257; fetch 16'h00A1 with ack in the same cycle as req; model alu_r per the decoder.
  - Required: rf_we pulses once 4 cycles after FETCH entry with rf_waddr=0 and rf_wdata=alu_r; pc 0→1; retired=1.
- Slow memory:
  - Stimulus: ack delayed 5 cycles on 16'h0021 (r0=16, r1=9).
  - Required: imem_req held high for all 6 cycles with imem_addr stable; exactly one rf_we.
- NOP then HALT:
  - Stimulus: fetch 16'h0000 with is_alu=0, then 16'hFFFF.
  - Required: no rf_we; pc=1, retired=1; halted=1; imem_req stays 0 for the following 20 cycles.
- PC wrap:
  - Stimulus: RESET_PC=255, PC_W=8, one ALU instruction.
  - Required: pc becomes 0 after WB.
- Reset mid-fetch:
  - Stimulus: assert reset during FETCH while an ack arrives in the same cycle.
  - Required: ir stays 0; next cycle state=IDLE with imem_req=0, pc=RESET_PC; FETCH resumes one cycle after reset deasserts.
- MY_SEQ_STEP_EN:
  - Stimulus: no step for 10 cycles, then a single step pulse.
  - Required: imem_req=0 while waiting; exactly one instruction retires per pulse; a second pulse while armed has no extra effect.

Source files
------------

// File: rtl/my_cpu16_pkg.sv
// my_cpu16_pkg: shared state encoding, IR field positions and the default HALT opcode
// for the CPU16 sequencer.
package my_cpu16_pkg;

    typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, WB, HALT} state_e;

    localparam int DST_HI = 3;
    localparam int DST_LO = 2;
    localparam int SRC_HI = 1;
    localparam int SRC_LO = 0;

    localparam logic [15:0] HALT_OPC_DEF = 16'hFFFF;

endpackage

// File: rtl/my_pc_counter.sv
// my_pc_counter: program counter with reset load and a wrapping increment.
module my_pc_counter #(
    parameter int              PC_W     = 8,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            inc_i,
    output logic [PC_W-1:0] pc_o
);

    logic [PC_W-1:0] pc_q, pc_d;

    assign pc_d = inc_i ? pc_q + PC_W'(1) : pc_q;

    always_ff @(posedge clk)
        pc_q <= reset ? RESET_PC : pc_d;

    assign pc_o = pc_q;

endmodule

// File: rtl/my_cpu16_sequencer.sv
// my_cpu16_sequencer: multi-cycle fetch/decode/exec/write-back control FSM for the CPU16 datapath.
// Define MY_SEQ_STEP_EN to add a step input that releases one instruction per pulse.
module my_cpu16_sequencer
    import my_cpu16_pkg::*;
#(
    parameter int              PC_W     = 8,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter logic [15:0]     HALT_OPC = HALT_OPC_DEF
) (
    input  logic            clk,
    input  logic            reset,
`ifdef MY_SEQ_STEP_EN
    input  logic            step,
`endif
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [15:0]     imem_data,
    output logic [15:0]     ir,
    input  logic            is_alu,
    input  logic [15:0]     alu_r,
    output logic [1:0]      rf_raddr_a,
    output logic [1:0]      rf_raddr_b,
    output logic            rf_we,
    output logic [1:0]      rf_waddr,
    output logic [15:0]     rf_wdata,
    output logic [PC_W-1:0] pc,
    output logic            halted,
    output logic [15:0]     retired
);

    state_e      state_q, state_d;
    logic [15:0] ir_q, ir_d, result_q, result_d, retired_q, retired_d;
    logic        rf_we_q, pc_inc, armed;

    my_pc_counter #(.PC_W(PC_W), .RESET_PC(RESET_PC)) u_pc (
        .clk   (clk),
        .reset (reset),
        .inc_i (pc_inc),
        .pc_o  (pc)
    );

`ifdef MY_SEQ_STEP_EN
    logic step_armed_q, step_armed_d;
    // Disarm whenever an instruction finishes (WB, NOP) or the core halts.
    assign step_armed_d = (state_q == WB || (state_q == DECODE && state_d != EXEC)) ? 1'b0
                        : (step_armed_q | step);
    always_ff @(posedge clk)
        step_armed_q <= reset ? 1'b0 : step_armed_d;
    assign armed = step_armed_q;
`else
    assign armed = 1'b1;
`endif

    always_comb begin
        state_d  = state_q;
        ir_d     = ir_q;
        result_d = result_q;
        pc_inc   = 1'b0;
        case (state_q)
            IDLE:   state_d = FETCH;
            FETCH:  if (imem_req && imem_ack) begin
                        ir_d    = imem_data;
                        state_d = DECODE;
                    end
            DECODE: begin
                        state_d = (ir_q == HALT_OPC) ? HALT : is_alu ? EXEC : FETCH;
                        pc_inc  = (ir_q != HALT_OPC) && !is_alu;
                    end
            EXEC:   begin
                        result_d = alu_r;
                        state_d  = WB;
                    end
            WB:     begin
                        pc_inc  = 1'b1;
                        state_d = FETCH;
                    end
            HALT:   state_d = HALT;
            default: state_d = IDLE;
        endcase
    end

    assign retired_d = retired_q + 16'(pc_inc);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            ir_q      <= '0;
            result_q  <= '0;
            retired_q <= '0;
            rf_we_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            result_q  <= result_d;
            retired_q <= retired_d;
            rf_we_q   <= (state_d == WB);
        end
    end

    assign imem_req   = (state_q == FETCH) && armed && !reset;
    assign imem_addr  = pc;
    assign ir         = ir_q;
    assign rf_raddr_a = ir_q[DST_HI:DST_LO];
    assign rf_raddr_b = ir_q[SRC_HI:SRC_LO];
    assign rf_we      = rf_we_q;
    assign rf_waddr   = ir_q[DST_HI:DST_LO];
    assign rf_wdata   = result_q;
    assign halted     = (state_q == HALT);
    assign retired    = retired_q;

endmodule

// File: tb/tb_my_cpu16_sequencer.sv
// tb_my_cpu16_sequencer: directed and random instruction streams against a per-instruction
// reference model; a second instance with RESET_PC=255 shares the stimulus to show PC wrap.
module tb_my_cpu16_sequencer;

    logic        clk = 1'b0;
    logic        reset, step, imem_ack, is_alu;
    logic [15:0] imem_data, alu_r;
    logic        imem_req, rf_we, halted;
    logic [7:0]  imem_addr, pc;
    logic [15:0] ir, rf_wdata, retired;
    logic [1:0]  rf_raddr_a, rf_raddr_b, rf_waddr;
    logic        d2_req, d2_we, d2_halted;
    logic [7:0]  d2_addr, d2_pc;
    logic [15:0] d2_ir, d2_wdata, d2_retired;
    logic [1:0]  d2_ra, d2_rb, d2_wa;

    logic [15:0] rf [4];
    logic [15:0] exp_rf [4];
    logic [7:0]  exp_pc;
    logic [15:0] exp_ret;
    int          n_chk = 0, n_fail = 0, req_n;

    always #5 clk = ~clk;

    my_cpu16_sequencer dut (
        .clk(clk), .reset(reset),
`ifdef MY_SEQ_STEP_EN
        .step(step),
`endif
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
        .ir(ir), .is_alu(is_alu), .alu_r(alu_r), .rf_raddr_a(rf_raddr_a), .rf_raddr_b(rf_raddr_b),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .pc(pc), .halted(halted),
        .retired(retired)
    );

    my_cpu16_sequencer #(.RESET_PC(8'd255)) dut2 (
        .clk(clk), .reset(reset),
`ifdef MY_SEQ_STEP_EN
        .step(step),
`endif
        .imem_req(d2_req), .imem_addr(d2_addr), .imem_ack(imem_ack), .imem_data(imem_data),
        .ir(d2_ir), .is_alu(is_alu), .alu_r(alu_r), .rf_raddr_a(d2_ra), .rf_raddr_b(d2_rb),
        .rf_we(d2_we), .rf_waddr(d2_wa), .rf_wdata(d2_wdata), .pc(d2_pc), .halted(d2_halted),
        .retired(d2_retired)
    );

    // Stub decoder/ALU: opcode in ir[7:4], 0 is a NOP, dst=ir[3:2], src=ir[1:0].
    function automatic logic [15:0] alu_model(input logic [3:0] op, input logic [15:0] a, b);
        case (op)
            4'h2:    return a - b;
            4'h3:    return a & b;
            4'h4:    return a | b;
            4'h5:    return a ^ b;
            default: return a + b;
        endcase
    endfunction

    assign is_alu = (ir != 16'hFFFF) && (ir[7:4] != 4'h0);
    assign alu_r  = alu_model(ir[7:4], rf[rf_raddr_a], rf[rf_raddr_b]);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        imem_ack = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        exp_pc = '0;
        exp_ret = '0;
    endtask

    task automatic set_reg(input int r, input logic [15:0] v);
        rf[r] = v;
        exp_rf[r] = v;
    endtask

    task automatic run_instr(input logic [15:0] instr, input int delay);
        int t = 0, we_n = 0, we_at = -1, held = 1;
        logic [7:0] a0, pc2;
        logic [15:0] wd = '0, expv;
        logic [1:0] wa = '0;
        logic alu, hlt;
        while (imem_req !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("req_wait", 32'(t < 50), 1);
        if (t >= 50) return;
        a0 = imem_addr;
        chk("imem_addr", a0, exp_pc);
        repeat (delay) begin
            @(negedge clk);
            if (imem_req === 1'b1 && imem_addr === a0) held++;
        end
        chk("req_held", held, delay + 1);
        imem_ack = 1'b1;
        imem_data = instr;
        @(negedge clk);
        imem_ack = 1'b0;
        imem_data = 16'($urandom);
        chk("ir", ir, instr);
        hlt = (instr == 16'hFFFF);
        alu = !hlt && instr[7:4] != 4'h0;
        expv = alu_model(instr[7:4], exp_rf[instr[3:2]], exp_rf[instr[1:0]]);
        for (int i = 0; i < 3; i++) begin
            if (rf_we === 1'b1) begin
                we_n++;
                we_at = i;
                wa = rf_waddr;
                wd = rf_wdata;
                rf[rf_waddr] = rf_wdata;
            end
            @(negedge clk);
        end
        chk("we_count", we_n, alu ? 1 : 0);
        if (alu) begin
            chk("we_cycle", we_at, 2);
            chk("waddr", wa, instr[3:2]);
            chk("wdata", wd, expv);
            exp_rf[instr[3:2]] = expv;
        end
        if (!hlt) begin
            exp_pc = exp_pc + 8'd1;
            exp_ret = exp_ret + 16'd1;
        end
        pc2 = exp_pc + 8'd255;
        chk("pc", pc, exp_pc);
        chk("pc_wrap", d2_pc, pc2);
        chk("retired", retired, exp_ret);
        chk("halted", halted, hlt);
    endtask

    initial begin
        logic [15:0] ins;
        reset = 1'b1;
        step = 1'b1;
        imem_ack = 1'b0;
        imem_data = 16'h0;
        for (int r = 0; r < 4; r++) set_reg(r, 16'($urandom));
        repeat (3) @(negedge clk);
        chk("rst_pc", pc, 0);
        chk("rst_pc2", d2_pc, 8'hFF);
        chk("rst_ir", ir, 0);
        chk("rst_retired", retired, 0);
        chk("rst_req", imem_req, 0);
        chk("rst_we", rf_we, 0);
        chk("rst_waddr", rf_waddr, 0);
        chk("rst_wdata", rf_wdata, 0);
        chk("rst_halted", halted, 0);
        reset = 1'b0;
        exp_pc = '0;
        exp_ret = '0;
        // ALU write-back with zero-wait ack; dut2 wraps 255 -> 0
        set_reg(0, 16'd65280);
        set_reg(1, 16'd257);
        run_instr(16'h00A1, 0);
        // slow memory
        set_reg(0, 16'd16);
        set_reg(1, 16'd9);
        run_instr(16'h0021, 5);
        // NOP then HALT
        do_reset();
        run_instr(16'h0000, 0);
        run_instr(16'hFFFF, 1);
        req_n = 0;
        repeat (20) begin
            @(negedge clk);
            if (imem_req !== 1'b0 || halted !== 1'b1) req_n++;
        end
        chk("halt_quiet", req_n, 0);
        // reset arriving together with an ack in FETCH
        do_reset();
        req_n = 0;
        while (imem_req !== 1'b1 && req_n < 10) begin
            @(negedge clk);
            req_n++;
        end
        chk("rst_fetch_reached", imem_req, 1);
        reset = 1'b1;
        imem_ack = 1'b1;
        imem_data = 16'h1234;
        #1 chk("req_drop_in_reset", imem_req, 0);
        @(negedge clk);
        imem_ack = 1'b0;
        chk("rst_mid_ir", ir, 0);
        chk("rst_mid_pc", pc, 0);
        chk("rst_mid_pc2", d2_pc, 8'hFF);
        reset = 1'b0;
        #1 chk("rst_idle_req", imem_req, 0);
        @(negedge clk);
        chk("rst_refetch_req", imem_req, 1);
        // random instruction stream
        do_reset();
        for (int n = 0; n < 40; n++) begin
            ins = 16'($urandom);
            if (ins == 16'hFFFF) ins[15] = 1'b0;
            run_instr(ins, int'($urandom_range(0, 3)));
        end
`ifdef MY_SEQ_STEP_EN
        step = 1'b0;
        do_reset();
        req_n = 0;
        repeat (10) begin
            @(negedge clk);
            if (imem_req !== 1'b0) req_n++;
        end
        chk("step_wait_req", req_n, 0);
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        run_instr(16'h0035, 1);
        req_n = 0;
        repeat (6) begin
            @(negedge clk);
            if (imem_req !== 1'b0) req_n++;
        end
        chk("step_single", req_n, 0);
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        @(negedge clk);
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        run_instr(16'h0046, 1);
        req_n = 0;
        repeat (6) begin
            @(negedge clk);
            if (imem_req !== 1'b0) req_n++;
        end
        chk("step_extra_ignored", req_n, 0);
        chk("step_retired", retired, 2);
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
